// File: rtl/sha512_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sha512_pkg                                                           |
// | SHA-512 constants, FSM state type and round helper functions.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package sha512_pkg;

  localparam int WORD_W     = 64;
  localparam int NUM_ROUNDS = 80;

  localparam logic [63:0] H0_IV = 64'h6a09e667f3bcc908;
  localparam logic [63:0] H1_IV = 64'hbb67ae8584caa73b;
  localparam logic [63:0] H2_IV = 64'h3c6ef372fe94f82b;
  localparam logic [63:0] H3_IV = 64'ha54ff53a5f1d36f1;
  localparam logic [63:0] H4_IV = 64'h510e527fade682d1;
  localparam logic [63:0] H5_IV = 64'h9b05688c2b3e6c1f;
  localparam logic [63:0] H6_IV = 64'h1f83d9abfb41bd6b;
  localparam logic [63:0] H7_IV = 64'h5be0cd19137e2179;

  localparam logic [8*WORD_W-1:0] IV = {H0_IV, H1_IV, H2_IV, H3_IV,
                                        H4_IV, H5_IV, H6_IV, H7_IV};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } state_t;

  function automatic logic [63:0] Sigma0(input logic [63:0] x);
    return {x[27:0], x[63:28]} ^ {x[33:0], x[63:34]} ^ {x[38:0], x[63:39]};
  endfunction

  function automatic logic [63:0] Sigma1(input logic [63:0] x);
    return {x[13:0], x[63:14]} ^ {x[17:0], x[63:18]} ^ {x[40:0], x[63:41]};
  endfunction

  function automatic logic [63:0] sigma0(input logic [63:0] x);
    return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ {7'b0, x[63:7]};
  endfunction

  function automatic logic [63:0] sigma1(input logic [63:0] x);
    return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ {6'b0, x[63:6]};
  endfunction

  function automatic logic [63:0] Ch(input logic [63:0] x, input logic [63:0] y,
                                     input logic [63:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [63:0] Maj(input logic [63:0] x, input logic [63:0] y,
                                      input logic [63:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha512_msg_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sha512_msg_sched                                                     |
// | 16-word sliding message-schedule window; o_w_t is the current W_t.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sha512_msg_sched
  import sha512_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_load,
  input  logic                   i_shift,
  input  logic [16*WORD_W-1:0]   i_block,
  output logic [WORD_W-1:0]      o_w_t
);

  logic [WORD_W-1:0] r_w [16];
  logic [WORD_W-1:0] w_next;

  // r_w[i] holds W[t+i]; the word entering at the top is W[t+16].
  assign w_next = sigma1(r_w[14]) + r_w[9] + sigma0(r_w[1]) + r_w[0];
  assign o_w_t  = r_w[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) r_w[i] <= '0;
    end else if (i_load) begin
      for (int i = 0; i < 16; i++) r_w[i] <= i_block[(16-i)*WORD_W-1 -: WORD_W];
    end else if (i_shift) begin
      for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
      r_w[15] <= w_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sha512_compress.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sha512_compress                                                      |
// | Iterative SHA-512 compression, one round per clock, chained H0..H7.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sha512_compress
  import sha512_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_blk_valid,
  output logic                   o_blk_ready,
  input  logic [16*WORD_W-1:0]   i_blk_data,
  input  logic                   i_blk_first,
  output logic [6:0]             o_k_addr,
  input  logic [WORD_W-1:0]      i_k_in,
  output logic                   o_digest_valid,
  output logic [8*WORD_W-1:0]    o_digest
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [6:0]           r_t;
  logic [WORD_W-1:0]    r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;
  logic [8*WORD_W-1:0]  r_hstate;
  logic                 r_dv;

  logic                 w_accept;
  logic                 w_round;
  logic                 w_final;
  logic [WORD_W-1:0]    w_wt;
  logic [WORD_W-1:0]    w_t1;
  logic [WORD_W-1:0]    w_t2;
  logic [8*WORD_W-1:0]  w_hb;
  logic [8*WORD_W-1:0]  w_work;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Ready is masked during reset so nothing can look accepted in that cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_round     = 1'b0;
    w_final     = 1'b0;
    o_blk_ready = 1'b0;
    case (r_state)
      IDLE: begin
        o_blk_ready = ~rst;
        w_accept    = i_blk_valid;
        if (i_blk_valid) w_state_nxt = ROUND;
      end
      ROUND: begin
        w_round = 1'b1;
        if (r_t == 7'(NUM_ROUNDS - 1)) w_state_nxt = FINAL;
      end
      FINAL: begin
        w_final     = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  sha512_msg_sched u_msg_sched (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_accept),
    .i_shift (w_round),
    .i_block (i_blk_data),
    .o_w_t   (w_wt)
  );

  assign w_hb   = i_blk_first ? IV : r_hstate;
  assign w_work = {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h};
  assign w_t1   = r_h + Sigma1(r_e) + Ch(r_e, r_f, r_g) + i_k_in + w_wt;
  assign w_t2   = Sigma0(r_a) + Maj(r_a, r_b, r_c);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_t      <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_d      <= '0;
      r_e      <= '0;
      r_f      <= '0;
      r_g      <= '0;
      r_h      <= '0;
      r_hstate <= IV;
      r_dv     <= 1'b0;
    end else begin
      r_dv <= w_final;
      if (w_accept) begin
        {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= w_hb;
        r_hstate <= w_hb;
        r_t      <= '0;
      end else if (w_round) begin
        r_a <= w_t1 + w_t2;
        r_b <= r_a;
        r_c <= r_b;
        r_d <= r_c;
        r_e <= r_d + w_t1;
        r_f <= r_e;
        r_g <= r_f;
        r_h <= r_g;
        r_t <= r_t + 7'd1;
      end else if (w_final) begin
        for (int i = 0; i < 8; i++) begin
          r_hstate[(8-i)*WORD_W-1 -: WORD_W] <= r_hstate[(8-i)*WORD_W-1 -: WORD_W]
                                              + w_work[(8-i)*WORD_W-1 -: WORD_W];
        end
      end
    end
  end

  assign o_k_addr       = w_round ? r_t : 7'd0;
  assign o_digest_valid = r_dv;
  assign o_digest       = r_hstate;

endmodule
`default_nettype wire
